// File: rtl/keypad_code_reader_pkg.sv
// Shared constants for the keypad code reader: key codes, display blank code,
// entry FSM state encoding and the keypad matrix map.
package keypad_code_reader_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd15;
    localparam logic [3:0] BLANK    = 4'hF;

    typedef logic [1:0] entry_state_t;

    localparam entry_state_t ST_IDLE  = 2'd0;
    localparam entry_state_t ST_ONE   = 2'd1;
    localparam entry_state_t ST_TWO   = 2'd2;
    localparam entry_state_t ST_VALID = 2'd3;

    // Matrix position to key code; col 0 is the leftmost column.
    function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] r4;
        logic [3:0] c4;
        r4 = {2'b00, row};
        c4 = {2'b00, col};
        if (row == 2'd3) begin
            case (col)
                2'd0:    key_at = KEY_STAR;
                2'd1:    key_at = 4'd0;
                default: key_at = KEY_HASH;
            endcase
        end else begin
            key_at = r4 * 4'd3 + c4 + 4'd1;
        end
    endfunction

endpackage

// File: rtl/keypad_code_reader_if.sv
// Code handshake between the keypad code reader (master) and the main FSM (slave).
interface keypad_code_reader_if;
    import keypad_code_reader_pkg::*;

    // code_valid rises with the code on digit1/digit2 and stays high, with the
    // digits frozen, until the slave asserts code_ack for at least one cycle;
    // the cycle after the ack code_valid drops and the digits blank.
    logic [3:0]   digit1;
    logic [3:0]   digit2;
    logic [1:0]   n_digits;
    logic         code_valid;
    logic         code_ack;
    logic         key_press;
    logic [3:0]   key_code;
    logic         key_err;
    entry_state_t entry_state;

    modport master (
        output digit1, digit2, n_digits, code_valid, key_press, key_code, key_err, entry_state,
        input  code_ack
    );

    modport slave (
        input  digit1, digit2, n_digits, code_valid, key_press, key_code, key_err, entry_state,
        output code_ack
    );

endinterface

// File: rtl/keypad_scan_debounce.sv
// Row scanner for a 4x3 keypad: column synchronizer, scan divider, per-frame
// decode with ghost rejection, and frame-based debounce producing key presses.
module keypad_scan_debounce
    import keypad_code_reader_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cols,
    output logic [3:0] rows,
    output logic       key_press,
    output logic [3:0] key_code,
    output logic       frame_tick
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_FRAMES);

    logic [2:0]       cols_meta;
    logic [2:0]       cols_sync;
    logic [DIV_W-1:0] div_cnt;
    logic             row_tick;
    logic [1:0]       row_idx;
    logic [1:0]       hit_cnt;
    logic [3:0]       hit_key;
    logic [3:0]       prev_result;
    logic [3:0]       accepted;
    logic [DB_W-1:0]  stable_cnt;

    logic [1:0]       row_hits;
    logic [3:0]       row_key;
    logic [2:0]       hit_sum;
    logic [1:0]       frame_hits;
    logic [3:0]       frame_key;
    logic [3:0]       frame_result;
    logic [DB_W-1:0]  stable_next;

    assign row_tick = (div_cnt == DIV_LAST);
    assign rows     = ~(4'b0001 << row_idx);

    // Hit counts saturate at 2: anything above one low key is a ghost.
    always_comb begin
        row_hits = 2'd0;
        row_key  = KEY_NONE;
        for (int c = 0; c < 3; c++) begin
            if (!cols_sync[c]) begin
                if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
                row_key = key_at(row_idx, 2'(c));
            end
        end
        hit_sum      = {1'b0, hit_cnt} + {1'b0, row_hits};
        frame_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_key    = (hit_cnt == 2'd0) ? row_key : hit_key;
        frame_result = (frame_hits == 2'd1) ? frame_key : KEY_NONE;
        if (frame_result != prev_result) begin
            stable_next = DB_W'(1);
        end else if (stable_cnt == DB_MAX) begin
            stable_next = stable_cnt;
        end else begin
            stable_next = stable_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cols_meta   <= 3'b111;
            cols_sync   <= 3'b111;
            div_cnt     <= '0;
            row_idx     <= 2'd0;
            hit_cnt     <= 2'd0;
            hit_key     <= KEY_NONE;
            prev_result <= KEY_NONE;
            accepted    <= KEY_NONE;
            stable_cnt  <= '0;
            key_press   <= 1'b0;
            key_code    <= 4'd0;
            frame_tick  <= 1'b0;
        end else begin
            cols_meta  <= cols;
            cols_sync  <= cols_meta;
            key_press  <= 1'b0;
            frame_tick <= 1'b0;
            if (row_tick) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
                if (row_idx == 2'd3) begin
                    hit_cnt     <= 2'd0;
                    hit_key     <= KEY_NONE;
                    prev_result <= frame_result;
                    stable_cnt  <= stable_next;
                    frame_tick  <= 1'b1;
                    // A release only updates the accepted key; it raises no event.
                    if (stable_next >= DB_MAX && frame_result != accepted) begin
                        accepted <= frame_result;
                        if (frame_result != KEY_NONE) begin
                            key_press <= 1'b1;
                            key_code  <= frame_result;
                        end
                    end
                end else begin
                    hit_cnt <= frame_hits;
                    hit_key <= frame_key;
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_code_reader.sv
// Keypad code reader top: scanner/debouncer plus the two-digit entry FSM.
// Optional partial-entry timeout enabled by defining KEYPAD_TIMEOUT_EN.
module keypad_code_reader
    import keypad_code_reader_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int TIMEOUT_FRAMES  = 2000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] rows,
    input  logic [2:0] cols,
    keypad_code_reader_if.master code
);

    entry_state_t state;
    logic         frame_tick;
    logic         is_digit;
    logic         timeout_hit;

    keypad_scan_debounce #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .cols       (cols),
        .rows       (rows),
        .key_press  (code.key_press),
        .key_code   (code.key_code),
        .frame_tick (frame_tick)
    );

    assign is_digit         = (code.key_code <= 4'd9);
    assign code.entry_state = state;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_FRAMES + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = frame_tick && !code.key_press
                         && (state == ST_ONE || state == ST_TWO)
                         && (to_cnt == TO_W'(TIMEOUT_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (rst || code.key_press || !(state == ST_ONE || state == ST_TWO)) begin
            to_cnt <= '0;
        end else if (frame_tick) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    // Partial entries are held indefinitely.
    assign timeout_hit = frame_tick && (TIMEOUT_FRAMES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            code.digit1     <= BLANK;
            code.digit2     <= BLANK;
            code.n_digits   <= 2'd0;
            code.code_valid <= 1'b0;
            code.key_err    <= 1'b0;
        end else begin
            code.key_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (code.key_press) begin
                        if (is_digit) begin
                            code.digit1   <= code.key_code;
                            code.n_digits <= 2'd1;
                            state         <= ST_ONE;
                        end else if (code.key_code == KEY_HASH) begin
                            code.key_err <= 1'b1;
                        end
                    end
                end
                ST_ONE: begin
                    if (code.key_press) begin
                        if (is_digit) begin
                            code.digit2   <= code.key_code;
                            code.n_digits <= 2'd2;
                            state         <= ST_TWO;
                        end else if (code.key_code == KEY_HASH) begin
                            code.key_err <= 1'b1;
                        end else begin
                            code.digit1   <= BLANK;
                            code.n_digits <= 2'd0;
                            state         <= ST_IDLE;
                        end
                    end else if (timeout_hit) begin
                        code.digit1   <= BLANK;
                        code.n_digits <= 2'd0;
                        code.key_err  <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                ST_TWO: begin
                    if (code.key_press) begin
                        if (code.key_code == KEY_HASH) begin
                            code.code_valid <= 1'b1;
                            state           <= ST_VALID;
                        end else if (is_digit) begin
                            code.key_err <= 1'b1;
                        end else begin
                            code.digit1   <= BLANK;
                            code.digit2   <= BLANK;
                            code.n_digits <= 2'd0;
                            state         <= ST_IDLE;
                        end
                    end else if (timeout_hit) begin
                        code.digit1   <= BLANK;
                        code.digit2   <= BLANK;
                        code.n_digits <= 2'd0;
                        code.key_err  <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    // Digits stay frozen and keys are ignored until consumed.
                    if (code.code_ack) begin
                        code.code_valid <= 1'b0;
                        code.digit1     <= BLANK;
                        code.digit2     <= BLANK;
                        code.n_digits   <= 2'd0;
                        state           <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_code_reader.sv
// Scoreboard bench for keypad_code_reader with a behavioural 4x3 keypad model.
// Expectations depend on KEYPAD_TIMEOUT_EN in the same way as the design.
module tb_keypad_code_reader;
    import keypad_code_reader_pkg::*;

    localparam int FRAME = 16;
    localparam logic [3:0] EV_PRESS = 4'd1;
    localparam logic [3:0] EV_ERR   = 4'd2;
    localparam logic [3:0] EV_SNAP  = 4'd3;
    localparam logic [3:0] EV_CLR   = 4'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rows;
    logic [2:0]  cols;
    logic [11:0] keys = 12'd0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic        prev_press = 1'b0;
    logic        prev_cv = 1'b0;

    keypad_code_reader_if code_if();

    keypad_code_reader #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (2),
        .TIMEOUT_FRAMES  (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rows (rows),
        .cols (cols),
        .code (code_if)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its column low while its row is driven.
    function automatic int key_of(int r, int c);
        if (r == 3) return (c == 0) ? 10 : (c == 1) ? 0 : 11;
        return r * 3 + c + 1;
    endfunction

    always_comb begin
        cols = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!rows[r] && keys[key_of(r, c)]) cols[c] = 1'b0;
    end

    function automatic logic [15:0] ev(logic [3:0] kind, logic [3:0] a, logic [3:0] b,
                                       logic [1:0] nd, logic cv);
        return {kind, a, b, nd, cv, 1'b0};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ev(string name, logic [15:0] act);
        logic [15:0] exp;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL %s: unexpected event %0h, nothing expected", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
            end
        end
    endtask

    // Monitor: every DUT output event is popped and compared in a fixed order.
    always @(negedge clk) begin
        if (rst) begin
            prev_press = 1'b0;
            prev_cv    = 1'b0;
        end else begin
            if (code_if.key_err)
                check_ev("key_err", ev(EV_ERR, code_if.digit1, code_if.digit2,
                                        code_if.n_digits, code_if.code_valid));
            if (prev_press)
                check_ev("entry_update", ev(EV_SNAP, code_if.digit1, code_if.digit2,
                                             code_if.n_digits, code_if.code_valid));
            if (prev_cv && !code_if.code_valid)
                check_ev("ack_clear", ev(EV_CLR, code_if.digit1, code_if.digit2,
                                          code_if.n_digits, code_if.code_valid));
            if (code_if.key_press)
                check_ev("key_press", ev(EV_PRESS, code_if.key_code, 4'd0, 2'd0, 1'b0));
            prev_press = code_if.key_press;
            prev_cv    = code_if.code_valid;
        end
    end

    task automatic exp_press(logic [3:0] k);
        exp_q.push_back(ev(EV_PRESS, k, 4'd0, 2'd0, 1'b0));
    endtask

    task automatic exp_snap(logic [3:0] a, logic [3:0] b, logic [1:0] nd, logic cv);
        exp_q.push_back(ev(EV_SNAP, a, b, nd, cv));
    endtask

    task automatic exp_err(logic [3:0] a, logic [3:0] b, logic [1:0] nd, logic cv);
        exp_q.push_back(ev(EV_ERR, a, b, nd, cv));
    endtask

    task automatic hold(logic [11:0] k, int clks);
        keys = k;
        repeat (clks) @(negedge clk);
    endtask

    task automatic press(int k, int hold_fr, int rel_fr);
        logic [11:0] m;
        m = 12'd1 << k;
        hold(m, hold_fr * FRAME);
        hold(12'd0, rel_fr * FRAME);
    endtask

    task automatic ack_pulse();
        code_if.code_ack = 1'b1;
        @(negedge clk);
        code_if.code_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_rows;
        code_if.code_ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_digit1", code_if.digit1, BLANK);
        check("rst_digit2", code_if.digit2, BLANK);
        check("rst_n_digits", code_if.n_digits, 0);
        check("rst_code_valid", code_if.code_valid, 0);
        check("rst_key_code", code_if.key_code, 0);
        check("rst_key_err", code_if.key_err, 0);
        for (int i = 0; i < 16; i++) begin
            exp_rows = ~(4'b0001 << ((i / 4) % 4));
            check("rows_scan", rows, exp_rows);
            @(negedge clk);
        end

        // '2' with a one-frame bounce, held 5 frames, then straight onto '*'.
        exp_press(4'd2);
        exp_snap(4'd2, BLANK, 2'd1, 1'b0);
        hold(12'd1 << 2, 8);
        hold(12'd0, 8);
        hold(12'd1 << 2, 5 * FRAME);
        exp_press(KEY_STAR);
        exp_snap(BLANK, BLANK, 2'd0, 1'b0);
        press(10, 3, 3);

        // 1, 3, # -> valid; '5' while valid is ignored; ack clears.
        exp_press(4'd1);  exp_snap(4'd1, BLANK, 2'd1, 1'b0); press(1, 3, 3);
        exp_press(4'd3);  exp_snap(4'd1, 4'd3, 2'd2, 1'b0);  press(3, 3, 3);
        exp_press(KEY_HASH); exp_snap(4'd1, 4'd3, 2'd2, 1'b1); press(11, 3, 3);
        exp_press(4'd5);  exp_snap(4'd1, 4'd3, 2'd2, 1'b1);  press(5, 3, 3);
        check("valid_held", code_if.code_valid, 1);
        exp_q.push_back(ev(EV_CLR, BLANK, BLANK, 2'd0, 1'b0));
        ack_pulse();

        // 7, stray ack, # error, * clear.
        exp_press(4'd7);  exp_snap(4'd7, BLANK, 2'd1, 1'b0); press(7, 3, 3);
        ack_pulse();
        check("ack_outside_valid_nd", code_if.n_digits, 1);
        check("ack_outside_valid_d1", code_if.digit1, 7);
        exp_press(KEY_HASH); exp_err(4'd7, BLANK, 2'd1, 1'b0);
        exp_snap(4'd7, BLANK, 2'd1, 1'b0); press(11, 3, 3);
        exp_press(KEY_STAR); exp_snap(BLANK, BLANK, 2'd0, 1'b0); press(10, 3, 3);

        // 4, 0, 9 (third digit rejected), clear, then a ghosted pair.
        exp_press(4'd4); exp_snap(4'd4, BLANK, 2'd1, 1'b0); press(4, 3, 3);
        exp_press(4'd0); exp_snap(4'd4, 4'd0, 2'd2, 1'b0);  press(0, 3, 3);
        exp_press(4'd9); exp_err(4'd4, 4'd0, 2'd2, 1'b0);
        exp_snap(4'd4, 4'd0, 2'd2, 1'b0); press(9, 3, 3);
        exp_press(KEY_STAR); exp_snap(BLANK, BLANK, 2'd0, 1'b0); press(10, 3, 3);
        hold((12'd1 << 4) | (12'd1 << 5), 3 * FRAME);
        hold(12'd0, 3 * FRAME);
        check("ghost_n_digits", code_if.n_digits, 0);

        // Partial entry left idle.
        exp_press(4'd8); exp_snap(4'd8, BLANK, 2'd1, 1'b0);
`ifdef KEYPAD_TIMEOUT_EN
        exp_err(BLANK, BLANK, 2'd0, 1'b0);
        press(8, 3, 3);
        repeat (8 * FRAME) @(negedge clk);
        check("timeout_digit1", code_if.digit1, BLANK);
        check("timeout_n_digits", code_if.n_digits, 0);
`else
        press(8, 3, 3);
        repeat (8 * FRAME) @(negedge clk);
        check("no_timeout_digit1", code_if.digit1, 8);
        check("no_timeout_n_digits", code_if.n_digits, 1);
        exp_press(KEY_STAR); exp_snap(BLANK, BLANK, 2'd0, 1'b0); press(10, 3, 3);
`endif

        // Reset in the middle of a two-digit entry.
        exp_press(4'd1); exp_snap(4'd1, BLANK, 2'd1, 1'b0); press(1, 3, 3);
        exp_press(4'd2); exp_snap(4'd1, 4'd2, 2'd2, 1'b0);  press(2, 3, 3);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("pre_rst_state_two", code_if.entry_state, ST_TWO);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_digit1", code_if.digit1, BLANK);
        check("mid_rst_digit2", code_if.digit2, BLANK);
        check("mid_rst_n_digits", code_if.n_digits, 0);
        check("mid_rst_code_valid", code_if.code_valid, 0);
        check("mid_rst_rows", rows, 4'b1110);
        check("mid_rst_key_code", code_if.key_code, 0);
        check("mid_rst_key_press", code_if.key_press, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_code_reader.md
Name: keypad_code_reader

Overview:
- Input-side counterpart of the multiplexed 4-digit display driver.
- Scans a 4x3 matrix keypad (rows driven, columns read) and debounces key presses.
- Assembles a two-digit product code and presents it to the vending-machine main FSM with a valid/ack handshake.
- Digit outputs use the display's blank code (4'hF), so the main FSM can route them directly to the display's digit inputs.

Parameters:
- SCAN_DIV, 50000: clk cycles each row is driven before its columns are sampled.
- DEBOUNCE_FRAMES, 4: consecutive identical full-scan frames required to accept a key change.
- TIMEOUT_FRAMES, 2000: idle frames before a partial entry is discarded (only with the optional feature).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- rows, output, 4: keypad row drive, active-low, one row low at a time.
- cols, input, 3: keypad columns, active-low (pulled up), asynchronous.
- digit1, output, 4: first code digit in BCD; 4'hF = blank.
- digit2, output, 4: second code digit in BCD; 4'hF = blank.
- n_digits, output, 2: digits currently entered (0..2).
- code_valid, output, 1: complete code held on digit1/digit2.
- code_ack, input, 1: main FSM has consumed the code.
- key_press, output, 1: one-cycle pulse per accepted key press.
- key_code, output, 4: code of the last accepted key (0-9 digits, 10 = '*', 11 = '#').
- key_err, output, 1: one-cycle pulse on a rejected key.

Behaviour:
- Reset values: rows=4'b1110, digit1=digit2=4'hF, n_digits=0, code_valid=0, key_press=0, key_err=0, key_code=0. All counters, debounce state and FSM cleared. Reset mid-entry or mid-VALID discards the code.
- Column sync: cols passes through a 2-flop synchronizer before any use.
- Scan timing:
  - Divider counts 0..SCAN_DIV-1; its wrap is row_tick.
  - On row_tick: sample the synchronized cols for the current row, then advance row_idx 0->1->2->3->0.
  - rows = ~(1<<row_idx).
  - One frame = 4 row_ticks; the frame ends at the row-3 sample.
- Key map (cols[0] = leftmost): row0 = 1 2 3; row1 = 4 5 6; row2 = 7 8 9; row3 = * 0 #.
- Frame result: exactly one key low in the frame gives that key. Zero keys, or two or more keys (ghosting), give NONE.
- Debounce:
  - At frame end, compare the frame result with the previous frame result.
  - Equal: increment the stable counter, saturating. Different: reload the counter to 1.
  - When the counter reaches DEBOUNCE_FRAMES and the result differs from the accepted key, update the accepted key.
  - Transition NONE->key: key_press pulses in the following cycle and key_code is updated in that same cycle.
  - Transition key->NONE: release, no event. A direct key->key change also produces a press.
  - Holding a key produces exactly one press.
- Entry FSM (acts on key_press; registered, so outputs change the cycle after key_press):
  - IDLE: digit -> digit1=d, n_digits=1, go to ONE. '#' -> key_err. '*' -> stay.
  - ONE: digit -> digit2=d, n_digits=2, go to TWO. '#' -> key_err. '*' -> clear.
  - TWO: '#' -> go to VALID, code_valid=1. digit -> key_err, digits unchanged. '*' -> clear.
  - Clear: digit1=digit2=4'hF, n_digits=0, go to IDLE.
  - VALID: digits frozen; all key presses ignored (no key_err). code_ack=1 -> next cycle code_valid=0 and clear.
  - code_ack outside VALID is ignored.
  - key_press coinciding with code_ack in VALID: the key is ignored.
- Scanning and debouncing run continuously in every FSM state.

Optional Feature:
- Macro: KEYPAD_TIMEOUT_EN.
- Defined: a frame counter runs in ONE and TWO, reset on every key_press. Reaching TIMEOUT_FRAMES triggers a clear and one key_err pulse. The counter is inactive in IDLE and VALID.
- Undefined: no timeout; a partial entry is held indefinitely. TIMEOUT_FRAMES is unused.

Decomposition:
- Shared package holds:
  - key code constants: KEY_STAR=10, KEY_HASH=11, KEY_NONE=15;
  - BLANK=4'hF, shared with the display driver;
  - the entry FSM state encoding (IDLE, ONE, TWO, VALID).
- One sub-module: keypad_scan_debounce. It contains the synchronizer, divider, row drive, frame decode and debounce, and outputs key_press/key_code. The top level contains the entry FSM and the timeout.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=2, TIMEOUT_FRAMES=8):
- Reset, no keys: rows cycle 1110->1101->1011->0111 every 4 clks; digit1=digit2=F; n_digits=0; no key_press.
- Hold '2' (row0/col1) for 5 frames with 1-frame bounce at the start: exactly one key_press with key_code=2; digit1=2, n_digits=1.
- Press 1, 3, # (releases between): code_valid=1, digit1=1, digit2=3. Press '5' while valid: no change, no key_err. code_ack 1 clk: next cycle code_valid=0, digits=F.
- Press 7 then #: key_err pulse, n_digits stays 1. Then '*': digits F, n_digits=0.
- Press 4, 0, 9: key_err on '9', digit2 stays 0. Press '4' and '5' simultaneously: no key_press.
- KEYPAD_TIMEOUT_EN defined: press '8', then idle 8 frames: key_err pulse, digits cleared. Same stimulus with the macro undefined: digit1=8 retained. Assert rst during TWO: all outputs return to reset values on the next clk.
